// File: rtl/prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch stage: word/instruction
// widths and the fetch FSM state encoding.
package prefetch_queue_pkg;

  localparam int INSTR_W = 32;
  localparam int WORD_W  = 16;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/prefetch_queue_if.sv
// Decoder handshake, redirect and memory-bus signals of the prefetch stage.
// master = prefetch_queue itself, slave = the decoder/memory environment.
interface prefetch_queue_if #(
  parameter int ADDR_W = 16
);
  import prefetch_queue_pkg::*;

  logic                rqi_p;
  logic                aki_n;
  logic [INSTR_W-1:0]  cmd_n;
  logic                flush_p;
  logic [ADDR_W-1:0]   flush_pc;
  logic                mem_req_p;
  logic [ADDR_W-1:0]   mem_adr_p;
  logic                mem_ack_n;
  logic [WORD_W-1:0]   mem_din_n;

  modport master (
    input  rqi_p, flush_p, flush_pc, mem_ack_n, mem_din_n,
    output aki_n, cmd_n, mem_req_p, mem_adr_p
  );

  modport slave (
    output rqi_p, flush_p, flush_pc, mem_ack_n, mem_din_n,
    input  aki_n, cmd_n, mem_req_p, mem_adr_p
  );

endinterface

// File: rtl/prefetch_queue_fifo.sv
// Circular word buffer: single-word push, two-word pop, synchronous clear.
// The two oldest words are always visible so the caller can register them.
module pq_fifo
  import prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop2,
  output logic [CNT_W-1:0]  count,
  output logic [WORD_W-1:0] old_word,
  output logic [WORD_W-1:0] young_word
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop2)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(2);
      case ({push, pop2})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(2);
        2'b11:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count      = count_reg;
  assign old_word   = mem[rd_ptr_reg];
  assign young_word = mem[rd_ptr_reg + PTR_W'(1)];

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch stage: fetches 16-bit words into a small queue and
// hands the decoder 32-bit pairs; a flush redirects fetching to a new PC.
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  prefetch_queue_if.master    bus
);

  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PAIR_CNT = CNT_W'(2);

  fetch_state_e       state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [ADDR_W-1:0]  adr_reg, adr_next;
  logic               discard_reg, discard_next;
  logic               push;
  logic               ack_fire;
  logic               aki_reg;
  logic [INSTR_W-1:0] cmd_reg;
  logic [CNT_W-1:0]   count;
  logic [WORD_W-1:0]  old_word;
  logic [WORD_W-1:0]  young_word;

  pq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (bus.flush_p),
    .push       (push),
    .push_data  (bus.mem_din_n),
    .pop2       (ack_fire),
    .count      (count),
    .old_word   (old_word),
    .young_word (young_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FETCH_IDLE;
      pc_reg      <= RESET_PC;
      adr_reg     <= RESET_PC;
      discard_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      adr_reg     <= adr_next;
      discard_reg <= discard_next;
    end
  end

  // A flush in IDLE only retargets the PC, so the next request is issued
  // one cycle later at flush_pc rather than at the stale PC.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    adr_next     = adr_reg;
    discard_next = discard_reg;
    push         = 1'b0;
    case (state_reg)
      FETCH_IDLE: begin
        if (bus.flush_p) begin
          pc_next = bus.flush_pc;
        end else if (count < FULL_CNT) begin
          state_next = FETCH_WAIT;
          adr_next   = pc_reg;
        end
      end
      FETCH_WAIT: begin
        if (bus.mem_ack_n) begin
          state_next   = FETCH_IDLE;
          discard_next = 1'b0;
          if (bus.flush_p) begin
            pc_next = bus.flush_pc;
          end else if (!discard_reg) begin
            push    = 1'b1;
            pc_next = pc_reg + ADDR_W'(1);
          end
        end else if (bus.flush_p) begin
          // The bus still owes us this word; drop it when it arrives.
          discard_next = 1'b1;
          pc_next      = bus.flush_pc;
        end
      end
      default: state_next = FETCH_IDLE;
    endcase
  end

  assign ack_fire = bus.rqi_p && !aki_reg && (count >= PAIR_CNT) && !bus.flush_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aki_reg <= 1'b0;
      cmd_reg <= '0;
    end else begin
      aki_reg <= ack_fire;
      if (ack_fire)
        cmd_reg <= {old_word, young_word};
    end
  end

  assign bus.aki_n     = aki_reg;
  assign bus.cmd_n     = cmd_reg;
  assign bus.mem_req_p = (state_reg == FETCH_WAIT);
  assign bus.mem_adr_p = adr_reg;

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- Instruction prefetch stage directly upstream of the decoder.
- Fetches 16-bit instruction words from the memory bus into a small word FIFO, advancing a fetch PC.
- Hands the decoder 32-bit instruction words (two queued words) over the rqi/aki handshake.
- Supports a redirect (flush) that discards queued and in-flight data and restarts fetching at a new PC.

Parameters:
- DEPTH, 4, queue capacity in 16-bit words; power of two, minimum 2.
- ADDR_W, 16, width of the word address / fetch PC.
- RESET_PC, 0, fetch PC loaded at reset.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- rqi_p  in  1  decoder requests the next instruction
- aki_n  out  1  one-cycle acknowledge; cmd_n valid in the same cycle
- cmd_n  out  32  instruction; [31:16] = older word, [15:0] = younger word
- flush_p  in  1  redirect request
- flush_pc  in  ADDR_W  new fetch PC, sampled when flush_p = 1
- mem_req_p  out  1  memory read request, held until acknowledged
- mem_adr_p  out  ADDR_W  word address, stable while mem_req_p = 1
- mem_ack_n  in  1  one-cycle memory acknowledge; mem_din_n valid in that cycle
- mem_din_n  in  16  read data

Behaviour:
- Reset values (async, while rst_n = 0):
  - aki_n = 0, cmd_n = 0, mem_req_p = 0, mem_adr_p = RESET_PC.
  - queue empty (count = 0), fetch PC = RESET_PC, discard flag = 0.
- Storage: circular buffer of DEPTH words with read pointer, write pointer and count (0..DEPTH). Pointers wrap modulo DEPTH.
- Fetch FSM, states IDLE and WAIT:
  - IDLE -> WAIT when count < DEPTH. The full check is sufficient because at most one fetch is in flight.
    - On entry: mem_req_p <= 1, mem_adr_p <= fetch PC.
  - WAIT: on mem_ack_n = 1, push mem_din_n (unless discarding), fetch PC += 1 (wraps at 2^ADDR_W), mem_req_p <= 0, go to IDLE.
  - Back-to-back requests are not permitted: there is at least one IDLE cycle between requests.
- Decoder handshake (aki_n and cmd_n registered):
  - At an edge where rqi_p = 1, count >= 2 and aki_n = 0: set aki_n <= 1, load cmd_n from the two oldest words, pop 2.
  - aki_n is high for exactly one cycle and never on two consecutive cycles.
  - cmd_n holds its value until the next acknowledge.
- Simultaneous push and pop on the same edge: count_next = count + 1 - 2.
  - A push is accepted whenever count < DEPTH before the edge; no overflow is possible.
- Flush, at an edge with flush_p = 1:
  - queue cleared; fetch PC <= flush_pc; aki_n <= 0; any pending acknowledge is suppressed.
  - No fetch in flight: next request issues at flush_pc.
  - Fetch in flight: mem_req_p stays high with its original address until acknowledged (bus protocol). The discard flag is set, the returning word is dropped, and the fetch PC is not incremented. The next request uses flush_pc.
  - Flush takes priority over a push or pop on the same edge.
- Reset mid-operation: all state is cleared immediately, including any outstanding request; the memory side must tolerate an abandoned request.
- Empty/one word with rqi_p = 1: aki_n stays 0 and the decoder waits.

Decomposition:
- Shared cpu package holds:
  - the fetch FSM state encodings (IDLE, WAIT);
  - the instruction width (32) and word width (16) constants.
- One natural sub-module, pq_fifo: word circular buffer with push, pop-2, clear and count outputs.
- The fetch FSM and the handshake logic stay in prefetch_queue.

Test Plan:
- Reset then idle memory (ack after 1 cycle, data = address): requests at 0, 1, 2, 3, then stalls with count = 4; mem_req_p = 0 while full.
- rqi_p held 1 after fill: aki_n pulses with cmd_n = 0x0000_0001, then after rqi_p is re-raised cmd_n = 0x0002_0003; aki_n is never high on two adjacent cycles.
- Slow memory (ack 5 cycles after request), rqi_p = 1 from cycle 0: no aki_n until 2 words are queued; first cmd_n = 0x0000_0001.
- flush_p with flush_pc = 0x0100 while a fetch to 0x0004 is outstanding: the 0x0004 data is discarded; the next request is 0x0100; the first cmd_n after the flush = 0x0100_0101.
- flush_p on the same edge as a would-be acknowledge: aki_n stays 0 and the queue is empty afterwards.
- rst_n pulled low mid-WAIT: all outputs are zero immediately; after release, fetching restarts at RESET_PC.
